// File: rtl/data_mem_arbiter_if.sv
// One requester port of the data memory arbiter: command, handshake and read result.
interface data_mem_arbiter_if;
    logic        req;
    logic        we;
    logic        mode;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        done;
    logic        err;
    logic [15:0] rdata;

    modport master (output req, we, mode, addr, wdata, input  done, err, rdata);
    modport slave  (input  req, we, mode, addr, wdata, output done, err, rdata);
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of DataMemory: IDLE -> ACCESS -> DONE per access,
// range errors skip ACCESS and complete directly.
module data_mem_arbiter #(
    parameter int ADDR_LIMIT = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    data_mem_arbiter_if.slave a_if,
    data_mem_arbiter_if.slave b_if,
    output logic              mem_rd_o,
    output logic              mem_wn_o,
    output logic              mem_mode_o,
    output logic [15:0]       mem_addr_o,
    output logic [15:0]       mem_wdata_o,
    input  logic [15:0]       mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [16:0] WORD_MAX = 17'(ADDR_LIMIT - 2);
    localparam logic [16:0] BYTE_MAX = 17'(ADDR_LIMIT - 1);

    state_t      state_q, state_d;
    logic        win_q, win_d;     // 0 = port A, 1 = port B
    logic        last_q, last_d;   // port granted most recently
    logic        we_q, we_d;
    logic        mode_q, mode_d;
    logic        err_q, err_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;

    logic        grant_b;
    logic        sel_we;
    logic        sel_mode;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;
    logic        range_err;
    logic        in_access;

    // Both requesting: the port that did not win last time takes this grant.
    always_comb begin
        grant_b   = b_if.req & (~a_if.req | ~last_q);
        sel_we    = grant_b ? b_if.we    : a_if.we;
        sel_mode  = grant_b ? b_if.mode  : a_if.mode;
        sel_addr  = grant_b ? b_if.addr  : a_if.addr;
        sel_wdata = grant_b ? b_if.wdata : a_if.wdata;
        range_err = sel_mode ? ({1'b0, sel_addr} > BYTE_MAX)
                             : ({1'b0, sel_addr} > WORD_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            we_q    <= we_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        we_d    = we_q;
        mode_d  = mode_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (a_if.req || b_if.req) begin
                    win_d   = grant_b;
                    last_d  = grant_b;
                    we_d    = sel_we;
                    mode_d  = sel_mode;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = range_err;
                    state_d = range_err ? DONE : ACCESS;
                end
            end
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_access   = (state_q == ACCESS);
    assign mem_rd_o    = in_access & ~we_q;
    assign mem_wn_o    = in_access & we_q;
    assign mem_mode_o  = in_access & mode_q;
    assign mem_addr_o  = in_access ? addr_q  : 16'h0000;
    assign mem_wdata_o = in_access ? wdata_q : 16'h0000;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        localparam logic PORT_ID = 1'(gi);
        logic        done;
        logic        err;
        logic [15:0] rdata_q;

        // Byte reads return the addressed byte, which DataMemory presents in the high half.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else if (in_access && !we_q && (win_q == PORT_ID)) begin
                rdata_q <= mode_q ? {8'h00, mem_rdata_i[15:8]} : mem_rdata_i;
            end
        end

        assign done = (state_q == DONE) && (win_q == PORT_ID);
        assign err  = done & err_q;
    end

    assign a_if.done  = g_port[0].done;
    assign a_if.err   = g_port[0].err;
    assign a_if.rdata = g_port[0].rdata_q;
    assign b_if.done  = g_port[1].done;
    assign b_if.err   = g_port[1].err;
    assign b_if.rdata = g_port[1].rdata_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vector table, reset and tie sequences,
// then a randomized two-port run scored against a transaction-level memory model.
module tb_data_mem_arbiter;
    localparam int ADDR_LIMIT = 2048;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_arbiter_if a_if();
    data_mem_arbiter_if b_if();

    logic        mem_rd, mem_wn, mem_mode;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    data_mem_arbiter #(.ADDR_LIMIT(ADDR_LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_if       (a_if),
        .b_if       (b_if),
        .mem_rd_o   (mem_rd),
        .mem_wn_o   (mem_wn),
        .mem_mode_o (mem_mode),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    // DataMemory: big-endian bytes, combinational read, write at the negedge inside ACCESS.
    logic [7:0] mem [0:4095];
    logic       mem_ready = 1'b0;
    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
            mem_ready <= 1'b1;
        end else if (mem_wn) begin
            if (mem_mode) begin
                mem[mem_addr[11:0]] <= mem_wdata[7:0];
            end else begin
                mem[mem_addr[11:0]]                 <= mem_wdata[15:8];
                mem[12'(mem_addr[11:0] + 12'd1)]    <= mem_wdata[7:0];
            end
        end
    end
    assign mem_rdata = {mem[mem_addr[11:0]], mem[12'(mem_addr[11:0] + 12'd1)]};

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic set_cmd(input int p, input logic r, input logic w, input logic m,
                           input logic [15:0] a, input logic [15:0] d);
        if (p == 0) begin
            a_if.req = r; a_if.we = w; a_if.mode = m; a_if.addr = a; a_if.wdata = d;
        end else begin
            b_if.req = r; b_if.we = w; b_if.mode = m; b_if.addr = a; b_if.wdata = d;
        end
    endtask

    function automatic logic get_done(input int p);
        return (p == 0) ? a_if.done : b_if.done;
    endfunction
    function automatic logic get_err(input int p);
        return (p == 0) ? a_if.err : b_if.err;
    endfunction
    function automatic logic [15:0] get_rdata(input int p);
        return (p == 0) ? a_if.rdata : b_if.rdata;
    endfunction

    typedef struct {
        int          p;
        logic        we;
        logic        mode;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    // Called at #1 after a posedge with the FSM in IDLE; returns with the FSM back in IDLE.
    task automatic run_txn(input vec_t v, output int lat, output logic err,
                           output logic [15:0] rd, output int strobes, output logic bus_ok);
        lat = 0; err = 1'b0; strobes = 0; bus_ok = 1'b1;
        set_cmd(v.p, 1'b1, v.we, v.mode, v.addr, v.wdata);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (mem_rd || mem_wn) begin
                strobes++;
                bus_ok = (mem_rd == !v.we) && (mem_wn == v.we) && (mem_addr == v.addr)
                      && (mem_mode == v.mode) && (mem_wdata == v.wdata);
            end
            if (get_done(v.p)) begin
                lat = c;
                err = get_err(v.p);
                break;
            end
        end
        rd = get_rdata(v.p);
        set_cmd(v.p, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge clk); #1;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int          lat, strobes;
        logic        err, bus_ok;
        logic [15:0] rd;
        run_txn(v, lat, err, rd, strobes, bus_ok);
        $display("txn %s port=%s we=%0d mode=%0d addr=0x%04h wdata=0x%04h -> lat=%0d err=%0d rdata=0x%04h",
                 tag, (v.p == 0) ? "A" : "B", v.we, v.mode, v.addr, v.wdata, lat, err, rd);
        check({tag, "_latency"}, lat, v.exp_err ? 1 : 2);
        check({tag, "_err"}, err, v.exp_err);
        check({tag, "_rdata"}, rd, v.exp_rdata);
        check({tag, "_strobe_cycles"}, strobes, v.exp_err ? 0 : 1);
        if (!v.exp_err) check({tag, "_bus"}, bus_ok, 1'b1);
    endtask

    logic [7:0]  ref_mem [0:4095];
    logic        pend [2];
    logic        pw   [2];
    logic        pm   [2];
    logic [15:0] pa   [2];
    logic [15:0] pd   [2];
    logic [15:0] ref_rd [2];

    initial begin
        vec_t vecs [13];
        int   tie_port [4];
        int   tie_cyc  [4];
        int   n_done;
        int   v_both, v_seq, v_spur, issued, dones;
        logic prev_rd, prev_wn, cur_rd, cur_wn, just_done, e_err;
        logic [15:0] prev_addr, cur_addr;

        vecs[0]  = '{0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
        vecs[1]  = '{0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
        vecs[2]  = '{1, 1'b0, 1'b1, 16'h0011, 16'h0000, 1'b0, 16'h00EF};
        vecs[3]  = '{1, 1'b1, 1'b1, 16'h0011, 16'h0042, 1'b0, 16'h00EF};
        vecs[4]  = '{0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBE42};
        vecs[5]  = '{0, 1'b0, 1'b0, 16'h07FF, 16'h0000, 1'b1, 16'hBE42};
        vecs[6]  = '{1, 1'b1, 1'b1, 16'h0800, 16'h0099, 1'b1, 16'h00EF};
        vecs[7]  = '{1, 1'b1, 1'b0, 16'h07FE, 16'h1234, 1'b0, 16'h00EF};
        vecs[8]  = '{0, 1'b0, 1'b1, 16'h07FF, 16'h0000, 1'b0, 16'h0034};
        vecs[9]  = '{1, 1'b0, 1'b0, 16'h07FE, 16'h0000, 1'b0, 16'h1234};
        vecs[10] = '{0, 1'b1, 1'b0, 16'h07FF, 16'h5555, 1'b1, 16'h0034};
        vecs[11] = '{0, 1'b0, 1'b1, 16'h0800, 16'h0000, 1'b1, 16'h0034};
        vecs[12] = '{0, 1'b0, 1'b0, 16'h07FE, 16'h0000, 1'b0, 16'h1234};

        set_cmd(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_cmd(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("rst_done_err", {a_if.done, b_if.done, a_if.err, b_if.err}, 4'h0);
        check("rst_strobes", {mem_rd, mem_wn, mem_mode}, 3'h0);
        check("rst_bus", {mem_addr, mem_wdata}, 32'h0);
        check("rst_rdata", {a_if.rdata, b_if.rdata}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) apply_vec(vecs[i], $sformatf("v%0d", i));

        // Both ports requesting straight out of reset: A first, then strict alternation.
        rst_n = 1'b0;
        set_cmd(0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        set_cmd(1, 1'b1, 1'b0, 1'b1, 16'h0011, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("tie_rst_rdata", {a_if.rdata, b_if.rdata}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        n_done = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (a_if.done || b_if.done) begin
                if (n_done < 4) begin
                    tie_port[n_done] = b_if.done ? 1 : 0;
                    tie_cyc[n_done]  = c;
                end
                $display("txn tie done port=%s cycle=%0d", b_if.done ? "B" : "A", c);
                n_done++;
            end
        end
        set_cmd(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_cmd(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("tie_done_count", n_done, 4);
        for (int k = 0; k < 4 && k < n_done; k++) begin
            check($sformatf("tie_port%0d", k), tie_port[k], k % 2);
            check($sformatf("tie_cycle%0d", k), tie_cyc[k], 2 + 3 * k);
        end
        check("tie_rdata", {a_if.rdata, b_if.rdata}, {16'hBE42, 16'h0042});

        // Reset asserted inside the ACCESS cycle of a write.
        set_cmd(0, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h5555);
        @(posedge clk); #1;
        check("abort_pre_strobe", {mem_wn, mem_addr}, {1'b1, 16'h0100});
        #2 rst_n = 1'b0;
        #1;
        check("abort_strobe_drop", {mem_rd, mem_wn, mem_addr}, 17'h0);
        set_cmd(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        n_done = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (a_if.done || b_if.done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_rdata_cleared", a_if.rdata, 16'h0000);
        apply_vec('{0, 1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0, 16'h0000}, "abort_rd");
        apply_vec('{1, 1'b1, 1'b0, 16'h0200, 16'h7788, 1'b0, 16'h0000}, "abort_wr2");
        apply_vec('{0, 1'b0, 1'b0, 16'h0200, 16'h0000, 1'b0, 16'h7788}, "abort_rd2");

        // Randomized run from a fresh reset so both rdata registers start at zero.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; pw[p] = 1'b0; pm[p] = 1'b0;
            pa[p] = 16'h0; pd[p] = 16'h0; ref_rd[p] = 16'h0;
        end
        v_both = 0; v_seq = 0; v_spur = 0; issued = 0; dones = 0;
        prev_rd = 1'b0; prev_wn = 1'b0; prev_addr = 16'h0;

        for (int cyc = 0; cyc < 10040; cyc++) begin
            @(posedge clk); #1;
            cur_rd = mem_rd; cur_wn = mem_wn; cur_addr = mem_addr;
            if (cur_rd && cur_wn) v_both++;
            if ((cur_rd || cur_wn) && (prev_rd || prev_wn)) v_seq++;
            if (a_if.done && b_if.done) v_seq++;
            if ((prev_rd || prev_wn) && !a_if.done && !b_if.done) v_seq++;
            for (int p = 0; p < 2; p++) begin
                just_done = 1'b0;
                if (get_done(p)) begin
                    just_done = 1'b1;
                    dones++;
                    if (!pend[p]) begin
                        v_spur++;
                    end else begin
                        e_err = pm[p] ? (pa[p] > 16'(ADDR_LIMIT - 1)) : (pa[p] > 16'(ADDR_LIMIT - 2));
                        if (!e_err) begin
                            if (!((prev_rd == !pw[p]) && (prev_wn == pw[p]) && (prev_addr == pa[p]))) v_seq++;
                            if (pw[p]) begin
                                if (pm[p]) begin
                                    ref_mem[pa[p][11:0]] = pd[p][7:0];
                                end else begin
                                    ref_mem[pa[p][11:0]]              = pd[p][15:8];
                                    ref_mem[12'(pa[p][11:0] + 12'd1)] = pd[p][7:0];
                                end
                            end else begin
                                ref_rd[p] = pm[p] ? {8'h00, ref_mem[pa[p][11:0]]}
                                                  : {ref_mem[pa[p][11:0]], ref_mem[12'(pa[p][11:0] + 12'd1)]};
                            end
                        end else if (prev_rd || prev_wn) begin
                            v_seq++;
                        end
                        $display("txn rnd cyc=%0d port=%s we=%0d mode=%0d addr=0x%04h -> err=%0d rdata=0x%04h",
                                 cyc, (p == 0) ? "A" : "B", pw[p], pm[p], pa[p], get_err(p), get_rdata(p));
                        check($sformatf("rnd%0d_err", cyc), get_err(p), e_err);
                        check($sformatf("rnd%0d_rdata", cyc), get_rdata(p), ref_rd[p]);
                        pend[p] = 1'b0;
                        set_cmd(p, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
                    end
                end
                if (!pend[p] && !just_done && cyc < 10000 && $urandom_range(0, 3) == 0) begin
                    pw[p] = 1'($urandom_range(0, 1));
                    pm[p] = 1'($urandom_range(0, 1));
                    pa[p] = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(ADDR_LIMIT - 3, ADDR_LIMIT + 2))
                                                        : 16'($urandom_range(0, ADDR_LIMIT + 1));
                    pd[p] = 16'($urandom_range(0, 65535));
                    pend[p] = 1'b1;
                    issued++;
                    set_cmd(p, 1'b1, pw[p], pm[p], pa[p], pd[p]);
                end
            end
            prev_rd = cur_rd; prev_wn = cur_wn; prev_addr = cur_addr;
        end
        check("rnd_strobes_exclusive", v_both, 0);
        check("rnd_strobe_sequence", v_seq, 0);
        check("rnd_spurious_done", v_spur, 0);
        check("rnd_done_per_request", dones, issued);
        check("rnd_drained", {pend[0], pend[1]}, 2'b00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
